// File: rtl/task_in_word_buffer_if.sv
// Byte-in / word-out bus for the task input word buffer.
// master: task manager + output stage side; slave: the buffer itself.
interface task_in_word_buffer_if #(
  parameter int WRITE_DATA_WIDTH = 8,
  parameter int READ_DATA_WIDTH  = 16,
  parameter int NUM_WORDS        = 50
);
  logic                               i_tdata_valid;
  logic [WRITE_DATA_WIDTH-1:0]        i_tdata;
  logic                               i_tdata_last;
  logic                               i_output_last;
  logic                               o_tready;
  logic [READ_DATA_WIDTH-1:0]         o_data;
  logic                               o_enb;
  logic                               o_overflow;
  logic [$clog2(NUM_WORDS+1)-1:0]     o_word_count;

  modport master (
    output i_tdata_valid, i_tdata, i_tdata_last, i_output_last,
    input  o_tready, o_data, o_enb, o_overflow, o_word_count
  );

  modport slave (
    input  i_tdata_valid, i_tdata, i_tdata_last, i_output_last,
    output o_tready, o_data, o_enb, o_overflow, o_word_count
  );
endinterface

// File: rtl/task_in_word_buffer.sv
// Task input word buffer: packs one packet of bytes little-endian into
// words, stores up to NUM_WORDS of them, replays them (plus optional zero
// flush words) as back-to-back strobes, then waits for the output stage.
module task_in_word_buffer #(
  parameter int WRITE_DATA_WIDTH = 8,
  parameter int READ_DATA_WIDTH  = 16,
  parameter int NUM_WORDS        = 50,
  parameter int FLUSH_WORDS      = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  task_in_word_buffer_if.slave bus
);
  localparam int BPW  = READ_DATA_WIDTH / WRITE_DATA_WIDTH;
  localparam int BW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNTW = $clog2(NUM_WORDS + 1);
  localparam int RW   = $clog2(NUM_WORDS + FLUSH_WORDS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, WAIT_OUT} state_t;

  state_t                     state_q, state_d;
  logic                       tready_q, tready_d;
  logic                       enb_q, enb_d;
  logic [READ_DATA_WIDTH-1:0] data_q, data_d;
  logic                       ovf_q, ovf_d;
  logic [CNTW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]              byte_idx_q, byte_idx_d;
  logic [READ_DATA_WIDTH-1:0] asm_q, asm_d;

  logic [READ_DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic                       mem_we;
  logic [READ_DATA_WIDTH-1:0] word_w;
  logic                       accept, full;
  logic [RW-1:0]              total;

  assign accept = bus.i_tdata_valid && tready_q;
  assign full   = (wr_ptr_q == CNTW'(NUM_WORDS));
  assign total  = RW'(wr_ptr_q) + RW'(FLUSH_WORDS);

  // Assembly register with the incoming byte merged into its lane.
  always_comb begin
    word_w = asm_q;
    for (int k = 0; k < BPW; k++)
      if (byte_idx_q == BW'(k))
        word_w[k*WRITE_DATA_WIDTH +: WRITE_DATA_WIDTH] = bus.i_tdata;
  end

  // Next-state logic for control, pointers and registered outputs.
  always_comb begin
    state_d    = state_q;
    tready_d   = tready_q;
    enb_d      = enb_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        tready_d = 1'b1;
        if (accept) begin
          state_d = LOAD;
          if (state_q == IDLE) ovf_d = 1'b0;
          if (full) begin
            // Capacity reached: keep draining the packet, remember it.
            ovf_d = 1'b1;
          end else if (bus.i_tdata_last || byte_idx_q == BW'(BPW-1)) begin
            // Complete word, or partial word closed by last (upper lanes
            // are still zero because asm clears after every write).
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + CNTW'(1);
            byte_idx_d = '0;
            asm_d      = '0;
          end else begin
            asm_d      = word_w;
            byte_idx_d = byte_idx_q + BW'(1);
          end
          if (bus.i_tdata_last) begin
            // First strobe goes out on the first PLAY cycle; word 0 may be
            // the one being written on this very edge.
            state_d  = PLAY;
            tready_d = 1'b0;
            enb_d    = 1'b1;
            data_d   = (wr_ptr_q == '0) ? word_w : mem[0];
            rd_ptr_d = RW'(1);
          end
        end
      end
      PLAY: begin
        if (rd_ptr_q < total) begin
          enb_d    = 1'b1;
          data_d   = (rd_ptr_q < RW'(wr_ptr_q)) ? mem[rd_ptr_q[AW-1:0]] : '0;
          rd_ptr_d = rd_ptr_q + RW'(1);
        end else begin
          enb_d   = 1'b0;
          state_d = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        enb_d = 1'b0;
        if (bus.i_output_last) begin
          state_d    = IDLE;
          tready_d   = 1'b1;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          byte_idx_d = '0;
          asm_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      tready_q   <= 1'b0;
      enb_q      <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      enb_q      <= enb_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
    end
  end

  // Word storage; contents survive reset, only pointers are cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst && mem_we) mem[wr_ptr_q[AW-1:0]] <= word_w;
  end

  assign bus.o_tready     = tready_q;
  assign bus.o_enb        = enb_q;
  assign bus.o_data       = data_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_word_count = wr_ptr_q;
endmodule

// File: tb/tb_task_in_word_buffer.sv
// Bench for task_in_word_buffer: directed and random packets compared
// against a packet-level model of packing, capacity, flush and handshake.
module tb_task_in_word_buffer;
  localparam int RDW = 16;
  localparam int NW  = 6;
  localparam int FW  = 2;
  localparam int BPW = RDW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  task_in_word_buffer_if #(.WRITE_DATA_WIDTH(8), .READ_DATA_WIDTH(RDW), .NUM_WORDS(NW)) bus ();

  task_in_word_buffer #(
    .WRITE_DATA_WIDTH(8), .READ_DATA_WIDTH(RDW), .NUM_WORDS(NW), .FLUSH_WORDS(FW)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus)
  );

  int nchk = 0;
  int nfail = 0;
  byte unsigned   pkt[$];
  logic [RDW-1:0] expw[$];
  int             exp_cnt;
  logic           exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Expected replay stream for the packet in pkt.
  task automatic model();
    int nw;
    logic [RDW-1:0] v;
    expw.delete();
    nw = (pkt.size() + BPW - 1) / BPW;
    if (nw > NW) nw = NW;
    for (int w = 0; w < nw; w++) begin
      v = '0;
      for (int k = 0; k < BPW; k++)
        if (w*BPW + k < pkt.size()) v = v | (RDW'(pkt[w*BPW + k]) << (8*k));
      expw.push_back(v);
    end
    exp_cnt = nw;
    exp_ovf = (pkt.size() > NW*BPW);
    for (int f = 0; f < FW; f++) expw.push_back('0);
  endtask

  task automatic fill(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  // Send pkt, check the replay, park in WAIT_OUT and release with
  // i_output_last. ol_play: strobe index at which a stray i_output_last is
  // pulsed; rst_at: strobe index at which reset is applied (-1 = none).
  task automatic run_packet(input bit gaps, input int ol_play, input int rst_at);
    int  i;
    logic v;
    i = 0;
    model();
    while (i < pkt.size()) begin
      chk("tready_load", bus.o_tready, 1);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_tdata_valid = v;
      bus.i_tdata       = v ? pkt[i] : 8'($urandom);
      bus.i_tdata_last  = v ? (i == pkt.size() - 1) : 1'($urandom_range(0, 1));
      step();
      if (v) begin
        i++;
        if (i == 1 && pkt.size() > 1) chk("ovf_clear", bus.o_overflow, 0);
      end
    end
    bus.i_tdata_valid = 1'b0;
    bus.i_tdata_last  = 1'b0;
    for (int j = 0; j < expw.size(); j++) begin
      if (j == rst_at) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("rst_enb", bus.o_enb, 0);
        chk("rst_tready", bus.o_tready, 0);
        chk("rst_count", 32'(bus.o_word_count), 0);
        chk("rst_ovf", bus.o_overflow, 0);
        chk("rst_data", 32'(bus.o_data), 0);
        step();
        chk("rst_rel_tready", bus.o_tready, 1);
        return;
      end
      chk("play_enb", bus.o_enb, 1);
      chk("play_data", 32'(bus.o_data), 32'(expw[j]));
      chk("play_tready", bus.o_tready, 0);
      bus.i_output_last = (j == ol_play);
      step();
      bus.i_output_last = 1'b0;
    end
    chk("done_enb", bus.o_enb, 0);
    chk("done_data_hold", 32'(bus.o_data), 32'(expw[expw.size()-1]));
    chk("done_tready", bus.o_tready, 0);
    chk("word_count", 32'(bus.o_word_count), 32'(exp_cnt));
    chk("overflow", bus.o_overflow, 32'(exp_ovf));
    repeat ($urandom_range(1, 4)) begin
      step();
      chk("wait_tready", bus.o_tready, 0);
      chk("wait_enb", bus.o_enb, 0);
    end
    bus.i_output_last = 1'b1; step(); bus.i_output_last = 1'b0;
    chk("idle_tready", bus.o_tready, 1);
    chk("idle_enb", bus.o_enb, 0);
    chk("idle_ovf_held", bus.o_overflow, 32'(exp_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_tdata_valid = 1'b0;
    bus.i_tdata       = '0;
    bus.i_tdata_last  = 1'b0;
    bus.i_output_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    chk("reset_tready", bus.o_tready, 0);
    chk("reset_enb", bus.o_enb, 0);
    chk("reset_data", 32'(bus.o_data), 0);
    chk("reset_ovf", bus.o_overflow, 0);
    chk("reset_count", 32'(bus.o_word_count), 0);
    rst_n = 1'b1;
    step();
    chk("release_tready", bus.o_tready, 1);

    // 8 sequential bytes -> 4 words + flush
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_packet(1'b0, -1, -1);
    // odd length, zero-filled tail word
    pkt = '{8'hAA, 8'hBB, 8'hCC};
    run_packet(1'b0, -1, -1);
    // exactly full, no overflow
    fill(NW*BPW);
    run_packet(1'b0, -1, -1);
    // overflow, then next packet clears the flag
    fill(NW*BPW + 3);
    run_packet(1'b0, -1, -1);
    // single byte
    fill(1);
    run_packet(1'b0, -1, -1);
    // valid gaps and a stray i_output_last during PLAY
    fill(7);
    run_packet(1'b1, 1, -1);
    // reset mid-PLAY, then a fresh packet replays only its own words
    fill(10);
    run_packet(1'b0, -1, 2);
    fill(2);
    run_packet(1'b0, -1, -1);
    // random packets
    for (int r = 0; r < 25; r++) begin
      fill($urandom_range(1, NW*BPW + 4));
      run_packet(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? 0 : -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/task_in_word_buffer.md
Name: task_in_word_buffer

Overview:
- Input stage of a task datapath: sits between the task input interface (byte stream from the task manager) and the processing system (e.g. a filter core).
- Collects one packet of bytes, packs them little-endian into READ_DATA_WIDTH words and stores up to NUM_WORDS words.
- Replays the stored words to the system with a one-cycle enable strobe per word.
- Re-arms for the next packet only after the output stage reports its last answer word.

Parameters:
- WRITE_DATA_WIDTH, 8: input byte width; fixed at 8.
- READ_DATA_WIDTH, 16: output word width; must be a multiple of 8 (BPW = READ_DATA_WIDTH/8).
- NUM_WORDS, 50: buffer depth in words.
- FLUSH_WORDS, 0: zero-valued words appended after the payload to drain the downstream pipeline.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_tdata_valid  in  1  input byte valid
- i_tdata  in  8  input byte
- i_tdata_last  in  1  marks the final byte of the packet (qualified by i_tdata_valid)
- i_output_last  in  1  pulse from the output stage: last answer word sent
- o_tready  out  1  data request to the task manager; a byte is accepted when i_tdata_valid && o_tready
- o_data  out  READ_DATA_WIDTH  word to the system; valid when o_enb=1
- o_enb  out  1  one-cycle strobe per word
- o_overflow  out  1  sticky flag: packet exceeded NUM_WORDS words
- o_word_count  out  $clog2(NUM_WORDS+1)  number of words stored for the current packet

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - State goes to IDLE.
  - All counters and the byte-assembly register clear.
  - Outputs: o_tready=0, o_enb=0, o_data=0, o_overflow=0, o_word_count=0.
  - Reset mid-packet discards buffered data; there is no partial resume.
- IDLE:
  - o_tready=1 from the first cycle after reset release.
  - The first accepted byte moves the block to LOAD; that byte is processed exactly like a LOAD byte.
- LOAD:
  - o_tready=1.
  - Byte k of a word (k = 0..BPW-1) goes to bits [8k+7:8k].
  - When byte BPW-1 is accepted, the word is written to buffer[wr_ptr], wr_ptr increments and o_word_count increments; all in the same edge.
  - While wr_ptr==NUM_WORDS:
    - Further bytes are accepted but dropped.
    - o_overflow is set and held until the next IDLE->LOAD transition.
    - The handshake is never stalled.
  - Accepted byte with i_tdata_last=1:
    - If a partial word is pending, it is written with its upper bytes zero-filled and counted (capacity permitting).
    - o_tready falls on the next cycle.
    - State goes to PLAY.
  - A packet of a single byte with last yields 1 word.
  - Bytes with i_tdata_valid=0 are ignored; o_tready holds.
- PLAY:
  - o_tready=0.
  - Starting on the first PLAY cycle, o_enb=1 on each of o_word_count + FLUSH_WORDS consecutive cycles (no gaps).
  - o_data = buffer[rd_ptr] for the payload words, then 0 for the flush words.
  - o_data and o_enb are registered; a word is presented in the same cycle as its strobe.
  - After the final strobe: o_enb=0 and o_data is held at its last value.
  - State goes to WAIT_OUT.
- WAIT_OUT:
  - o_tready=0, o_enb=0.
  - i_output_last=1 sampled here -> IDLE on the next edge.
  - i_output_last during LOAD or PLAY is ignored (no effect, not remembered).
- Latency: last byte accepted at cycle N -> first o_enb at cycle N+1.
- Pointers never wrap within a packet. rd_ptr and wr_ptr clear on entry to IDLE.
- Buffer memory contents are not cleared by reset; only pointers and counters are. Stale data is never output.

Test Plan:
- Reset, then 8 bytes 0x01..0x08 with last on 0x08 (BPW=2) -> 4 consecutive o_enb pulses starting 1 cycle after last, o_data = 0x0201, 0x0403, 0x0605, 0x0807; then o_tready=0 until i_output_last pulse; o_tready=1 the cycle after return to IDLE.
- 3 bytes 0xAA, 0xBB, 0xCC with last -> 2 strobes, o_data = 0xBBAA, 0x00CC; o_word_count=2.
- NUM_WORDS=4, 12 bytes -> o_tready stays 1 throughout; 4 strobes with the first 8 bytes packed; o_overflow=1; o_overflow clears on the first byte of the next packet.
- FLUSH_WORDS=3, 4-byte packet -> 5 consecutive strobes: 2 data words, then 3 words of 0x0000.
- i_tdata_valid toggling 1/0 per cycle and i_output_last pulsed during PLAY -> packing unaffected by gaps; PLAY completes normally; block remains in WAIT_OUT until a later i_output_last.
- Assert i_rst=0 for 1 cycle mid-PLAY -> next cycle o_enb=0, o_tready=0, counts 0; o_tready=1 after release; a new packet replays only its own words.
